// File: rtl/up_dn_pkg.sv
// Shared defaults and command encoding for the Up_Dn_Counter command stage.
package up_dn_pkg;

    localparam int unsigned WIDTH_DEF     = 5;
    localparam int unsigned DB_CYCLES_DEF = 4;
    localparam int unsigned DB_W_DEF      = 8;

    // Arbitration winner; Load outranks Up, Up outranks Down
    typedef enum logic [1:0] {
        CMD_NONE = 2'd0,
        CMD_LOAD = 2'd1,
        CMD_UP   = 2'd2,
        CMD_DOWN = 2'd3
    } cmd_t;

endpackage

// File: rtl/btn_debounce.sv
// One raw push-button: 2-flop synchronizer, symmetric debounce, registered press pulse.
module btn_debounce
    import up_dn_pkg::*;
#(
    parameter int unsigned DB_CYCLES = DB_CYCLES_DEF,
    parameter int unsigned DB_W      = DB_W_DEF
) (
    input  logic Clk,
    input  logic Rst,
    input  logic Btn,
    output logic Press
);

    logic            sync1;
    logic            sync2;
    logic            stable;
    logic [DB_W-1:0] cnt;

    // Stable level flips on the DB_CYCLES-th consecutive differing sample;
    // Press fires on that same edge only for a rising change.
    always_ff @(posedge Clk or posedge Rst) begin
        if (Rst) begin
            sync1  <= 1'b0;
            sync2  <= 1'b0;
            stable <= 1'b0;
            cnt    <= '0;
            Press  <= 1'b0;
        end else begin
            sync1 <= Btn;
            sync2 <= sync1;
            Press <= 1'b0;
            if (sync2 == stable) begin
                cnt <= '0;
            end else if (cnt == DB_W'(DB_CYCLES - 1)) begin
                stable <= sync2;
                cnt    <= '0;
                Press  <= sync2;
            end else begin
                cnt <= cnt + 1'b1;
            end
        end
    end

endmodule

// File: rtl/up_dn_cmd_ctrl.sv
// Turns debounced button presses and a switch bank into Load/Up/Down/IN for the
// up/down counter, with priority arbitration and a saturation guard.
module up_dn_cmd_ctrl
    import up_dn_pkg::*;
#(
    parameter int unsigned WIDTH     = WIDTH_DEF,
    parameter int unsigned DB_CYCLES = DB_CYCLES_DEF,
    parameter int unsigned DB_W      = DB_W_DEF
) (
    input  logic             Clk,
    input  logic             Rst,
    input  logic             Btn_Up,
    input  logic             Btn_Dn,
    input  logic             Btn_Load,
    input  logic [WIDTH-1:0] Sw_In,
    input  logic             High,
    input  logic             Low,
    output logic             Up,
    output logic             Down,
    output logic             Load,
    output logic [WIDTH-1:0] IN,
    output logic             Drop
);

    logic             up_ev;
    logic             dn_ev;
    logic             ld_ev;
    logic [WIDTH-1:0] sw_s1;
    logic [WIDTH-1:0] sw_s2;
    cmd_t             win_c;
    logic             drop_c;

    btn_debounce #(.DB_CYCLES(DB_CYCLES), .DB_W(DB_W)) u_db_up (
        .Clk(Clk), .Rst(Rst), .Btn(Btn_Up), .Press(up_ev)
    );

    btn_debounce #(.DB_CYCLES(DB_CYCLES), .DB_W(DB_W)) u_db_dn (
        .Clk(Clk), .Rst(Rst), .Btn(Btn_Dn), .Press(dn_ev)
    );

    btn_debounce #(.DB_CYCLES(DB_CYCLES), .DB_W(DB_W)) u_db_ld (
        .Clk(Clk), .Rst(Rst), .Btn(Btn_Load), .Press(ld_ev)
    );

    // A blocked Up still outranks Down, so Down is dropped rather than promoted
    always_comb begin
        win_c  = CMD_NONE;
        drop_c = 1'b0;
        if (ld_ev) begin
            win_c  = CMD_LOAD;
            drop_c = up_ev | dn_ev;
        end else if (up_ev) begin
            if (!High) begin
                win_c = CMD_UP;
            end
            drop_c = High | dn_ev;
        end else if (dn_ev) begin
            if (!Low) begin
                win_c = CMD_DOWN;
            end
            drop_c = Low;
        end
    end

    always_ff @(posedge Clk or posedge Rst) begin
        if (Rst) begin
            sw_s1 <= '0;
            sw_s2 <= '0;
            Up    <= 1'b0;
            Down  <= 1'b0;
            Load  <= 1'b0;
            Drop  <= 1'b0;
            IN    <= '0;
        end else begin
            sw_s1 <= Sw_In;
            sw_s2 <= sw_s1;
            Up    <= (win_c == CMD_UP);
            Down  <= (win_c == CMD_DOWN);
            Load  <= (win_c == CMD_LOAD);
            Drop  <= drop_c;
            if (win_c == CMD_LOAD) begin
                IN <= sw_s2;
            end
        end
    end

endmodule

// File: tb/tb_up_dn_cmd_ctrl.sv
// Directed, table-driven bench for up_dn_cmd_ctrl with DB_CYCLES=4.
module tb_up_dn_cmd_ctrl;

    localparam int unsigned WIDTH = 5;

    logic             Clk = 1'b0;
    logic             Rst = 1'b1;
    logic             Btn_Up = 1'b0;
    logic             Btn_Dn = 1'b0;
    logic             Btn_Load = 1'b0;
    logic [WIDTH-1:0] Sw_In = '0;
    logic             High = 1'b0;
    logic             Low = 1'b0;
    logic             Up;
    logic             Down;
    logic             Load;
    logic [WIDTH-1:0] IN;
    logic             Drop;

    up_dn_cmd_ctrl #(.WIDTH(WIDTH), .DB_CYCLES(4), .DB_W(8)) dut (
        .Clk(Clk), .Rst(Rst), .Btn_Up(Btn_Up), .Btn_Dn(Btn_Dn),
        .Btn_Load(Btn_Load), .Sw_In(Sw_In), .High(High), .Low(Low),
        .Up(Up), .Down(Down), .Load(Load), .IN(IN), .Drop(Drop)
    );

    always #5 Clk = ~Clk;

    // One row = inputs driven before an edge, outputs expected just after it
    typedef struct {
        string            tag;
        logic             rst;
        logic             bu;
        logic             bd;
        logic             bl;
        logic [WIDTH-1:0] sw;
        logic             hi;
        logic             lo;
        logic [3:0]       eo;   // {Up, Down, Load, Drop}
        logic [WIDTH-1:0] ein;
    } vec_t;

    vec_t vq[$];
    int   tests = 0;
    int   fails = 0;

    task automatic chk(input int idx, input string tag,
                       input logic [3+WIDTH:0] got, input logic [3+WIDTH:0] exp);
        tests++;
        if (got !== exp) begin
            fails++;
            $display("FAIL row %0d %s: got up/dn/ld/drop=%b in=%0d, want up/dn/ld/drop=%b in=%0d",
                     idx, tag, got[3+WIDTH:WIDTH], got[WIDTH-1:0],
                     exp[3+WIDTH:WIDTH], exp[WIDTH-1:0]);
        end
    endtask

    task automatic add(input string tag, input int n, input logic rst,
                       input logic bu, input logic bd, input logic bl,
                       input logic [WIDTH-1:0] sw, input logic hi, input logic lo,
                       input logic [3:0] eo, input logic [WIDTH-1:0] ein);
        vec_t v;
        v.tag = tag; v.rst = rst; v.bu = bu; v.bd = bd; v.bl = bl;
        v.sw = sw; v.hi = hi; v.lo = lo; v.eo = eo; v.ein = ein;
        for (int k = 0; k < n; k++) vq.push_back(v);
    endtask

    // Press pattern: 6 quiet rows, the event row (edge 7), 3 more held rows, 8 idle rows
    task automatic press(input string tag, input logic bu, input logic bd, input logic bl,
                         input logic [WIDTH-1:0] sw, input logic hi, input logic lo,
                         input logic [3:0] eo, input logic [WIDTH-1:0] in_pre,
                         input logic [WIDTH-1:0] in_post, input logic [WIDTH-1:0] sw_idle);
        add({tag, "_wait"}, 6, 1'b0, bu, bd, bl, sw, hi, lo, 4'b0000, in_pre);
        add({tag, "_evt"},  1, 1'b0, bu, bd, bl, sw, hi, lo, eo, in_post);
        add({tag, "_hold"}, 3, 1'b0, bu, bd, bl, sw, hi, lo, 4'b0000, in_post);
        add({tag, "_idle"}, 8, 1'b0, 1'b0, 1'b0, 1'b0, sw_idle, 1'b0, 1'b0, 4'b0000, in_post);
    endtask

    function automatic bit is_wait(input string tag);
        int n;
        n = tag.len();
        return (n >= 5) && (tag.substr(n - 5, n - 1) == "_wait");
    endfunction

    initial begin
        logic [3+WIDTH:0] got;
        logic [3+WIDTH:0] exp;

        add("reset", 3, 1'b1, 1'b0, 1'b0, 1'b0, 5'd0, 1'b0, 1'b0, 4'b0000, 5'd0);

        // Clean Up press held 20 cycles
        add("clean_wait", 6, 1'b0, 1'b1, 1'b0, 1'b0, 5'd0, 1'b0, 1'b0, 4'b0000, 5'd0);
        add("clean_evt",  1, 1'b0, 1'b1, 1'b0, 1'b0, 5'd0, 1'b0, 1'b0, 4'b1000, 5'd0);
        add("clean_hold", 13, 1'b0, 1'b1, 1'b0, 1'b0, 5'd0, 1'b0, 1'b0, 4'b0000, 5'd0);
        add("clean_idle", 8, 1'b0, 1'b0, 1'b0, 1'b0, 5'd0, 1'b0, 1'b0, 4'b0000, 5'd0);

        // Bouncing Down: 1,0,1,0 then held
        add("bounce_hi", 1, 1'b0, 1'b0, 1'b1, 1'b0, 5'd0, 1'b0, 1'b0, 4'b0000, 5'd0);
        add("bounce_lo", 1, 1'b0, 1'b0, 1'b0, 1'b0, 5'd0, 1'b0, 1'b0, 4'b0000, 5'd0);
        add("bounce_hi", 1, 1'b0, 1'b0, 1'b1, 1'b0, 5'd0, 1'b0, 1'b0, 4'b0000, 5'd0);
        add("bounce_lo", 1, 1'b0, 1'b0, 1'b0, 1'b0, 5'd0, 1'b0, 1'b0, 4'b0000, 5'd0);
        press("bounce", 1'b0, 1'b1, 1'b0, 5'd0, 1'b0, 1'b0, 4'b0100, 5'd0, 5'd0, 5'd0);

        // Load value 9, then switches move to 3 without a press
        press("load9", 1'b0, 1'b0, 1'b1, 5'd9, 1'b0, 1'b0, 4'b0010, 5'd0, 5'd9, 5'd3);

        // Load and Up together: Load wins, Up dropped
        press("ld_up", 1'b1, 1'b0, 1'b1, 5'd3, 1'b0, 1'b0, 4'b0011, 5'd9, 5'd3, 5'd3);

        // Up and Down together: Up wins, Down dropped
        press("up_dn", 1'b1, 1'b1, 1'b0, 5'd3, 1'b0, 1'b0, 4'b1001, 5'd3, 5'd3, 5'd3);

        // Saturation guards
        press("sat_hi", 1'b1, 1'b0, 1'b0, 5'd3, 1'b1, 1'b0, 4'b0001, 5'd3, 5'd3, 5'd3);
        press("sat_lo", 1'b0, 1'b1, 1'b0, 5'd3, 1'b0, 1'b1, 4'b0001, 5'd3, 5'd3, 5'd3);
        press("hi_updn", 1'b1, 1'b1, 1'b0, 5'd3, 1'b1, 1'b0, 4'b0001, 5'd3, 5'd3, 5'd3);

        // Low only guards Down; an Up press still goes through
        press("lo_up", 1'b1, 1'b0, 1'b0, 5'd3, 1'b0, 1'b1, 4'b1000, 5'd3, 5'd3, 5'd3);

        // Reset mid-debounce with Up held throughout
        add("rmid_pre", 3, 1'b0, 1'b1, 1'b0, 1'b0, 5'd3, 1'b0, 1'b0, 4'b0000, 5'd3);
        add("rmid_rst", 2, 1'b1, 1'b1, 1'b0, 1'b0, 5'd3, 1'b0, 1'b0, 4'b0000, 5'd0);
        press("rmid", 1'b1, 1'b0, 1'b0, 5'd3, 1'b0, 1'b0, 4'b1000, 5'd0, 5'd0, 5'd3);

        // Reset asserted on the edge where Down would fire
        add("rpulse_wait", 6, 1'b0, 1'b0, 1'b1, 1'b0, 5'd3, 1'b0, 1'b0, 4'b0000, 5'd0);
        add("rpulse_rst",  1, 1'b1, 1'b0, 1'b1, 1'b0, 5'd3, 1'b0, 1'b0, 4'b0000, 5'd0);
        add("rpulse_idle", 8, 1'b0, 1'b0, 1'b0, 1'b0, 5'd3, 1'b0, 1'b0, 4'b0000, 5'd0);

        // Reset-state check before replaying the table
        @(posedge Clk);
        #1;
        chk(-1, "reset_state", {Up, Down, Load, Drop, IN}, '0);

        foreach (vq[i]) begin
            @(negedge Clk);
            Rst      = vq[i].rst;
            Btn_Up   = vq[i].bu;
            Btn_Dn   = vq[i].bd;
            Btn_Load = vq[i].bl;
            Sw_In    = vq[i].sw;
            High     = vq[i].hi;
            Low      = vq[i].lo;
            @(posedge Clk);
            #1;
            got = {Up, Down, Load, Drop, IN};
            exp = {vq[i].eo, vq[i].ein};
            if (is_wait(vq[i].tag)) begin
                chk(i, {vq[i].tag, "_expired"}, got, exp);
            end else begin
                chk(i, vq[i].tag, got, exp);
            end
        end

        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule
